// File: rtl/alu_operand_fetch_if.sv
// Signal bundle between the decoder, internal RAM read port, ALU and the operand-fetch stage.
// The slave modport is the fetch stage's view; master is the surrounding logic's view.
interface alu_operand_fetch_if #(
  parameter int RAM_AW = 8
);
  logic              start;
  logic [4:0]        op_in;
  logic [2:0]        a_mode;
  logic [7:0]        a_sel;
  logic [2:0]        b_mode;
  logic [7:0]        b_sel;
  logic [7:0]        acc;
  logic [7:0]        psw;
  logic [7:0]        ram_rd_data;
  logic              ram_rd_en;
  logic [RAM_AW-1:0] ram_rd_addr;
  logic [7:0]        a_data;
  logic [7:0]        b_data;
  logic [4:0]        alu_op;
  logic              alu_en;
  logic              busy;

  modport master (
    output start, op_in, a_mode, a_sel, b_mode, b_sel, acc, psw, ram_rd_data,
    input  ram_rd_en, ram_rd_addr, a_data, b_data, alu_op, alu_en, busy
  );

  modport slave (
    input  start, op_in, a_mode, a_sel, b_mode, b_sel, acc, psw, ram_rd_data,
    output ram_rd_en, ram_rd_addr, a_data, b_data, alu_op, alu_en, busy
  );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: gathers two 8-bit operands (ACC, immediate, Rn, direct, @Ri)
// through one synchronous RAM read port, then strobes alu_en for one cycle.
module alu_operand_fetch #(
  parameter int RAM_AW = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_operand_fetch_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, A_ISSUE, A_IND, A_CAP, B_ISSUE, B_IND, B_CAP, EXEC
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [2:0] aMode_q, aMode_d, bMode_q, bMode_d;
  logic [7:0] aSel_q, aSel_d, bSel_q, bSel_d;
  logic [7:0] acc_q, acc_d;
  logic [1:0] bank_q, bank_d;
  logic [7:0] aData_q, aData_d, bData_q, bData_d;
  logic       rdEn;
  logic [7:0] rawAddr;
  logic       unusedPsw;

  assign unusedPsw = ^{bus.psw[7:5], bus.psw[2:0]};

  function automatic logic needsRam(input logic [2:0] mode);
    return (mode == 3'd1) || (mode == 3'd2) || (mode == 3'd3);
  endfunction

  function automatic logic [7:0] directValue(input logic [2:0] mode,
                                             input logic [7:0] sel,
                                             input logic [7:0] accVal);
    case (mode)
      3'd0:    return accVal;
      3'd4:    return sel;
      default: return 8'h00;
    endcase
  endfunction

  // First read address: register-bank slot for Rn and the @Ri pointer, raw sel for direct.
  function automatic logic [7:0] issueAddr(input logic [2:0] mode,
                                           input logic [7:0] sel,
                                           input logic [1:0] bank);
    case (mode)
      3'd1:    return {3'b000, bank, sel[2:0]};
      3'd3:    return {3'b000, bank, 2'b00, sel[0]};
      default: return sel;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    aMode_d = aMode_q;
    aSel_d  = aSel_q;
    bMode_d = bMode_q;
    bSel_d  = bSel_q;
    acc_d   = acc_q;
    bank_d  = bank_q;
    aData_d = aData_q;
    bData_d = bData_q;
    rdEn    = 1'b0;
    rawAddr = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op_in;
          aMode_d = bus.a_mode;
          aSel_d  = bus.a_sel;
          bMode_d = bus.b_mode;
          bSel_d  = bus.b_sel;
          acc_d   = bus.acc;
          bank_d  = bus.psw[4:3];
          if (needsRam(bus.a_mode)) begin
            state_d = A_ISSUE;
          end else begin
            aData_d = directValue(bus.a_mode, bus.a_sel, bus.acc);
            if (needsRam(bus.b_mode)) begin
              state_d = B_ISSUE;
            end else begin
              bData_d = directValue(bus.b_mode, bus.b_sel, bus.acc);
              state_d = EXEC;
            end
          end
        end
      end
      A_ISSUE: begin
        rdEn    = 1'b1;
        rawAddr = issueAddr(aMode_q, aSel_q, bank_q);
        state_d = (aMode_q == 3'd3) ? A_IND : A_CAP;
      end
      A_IND: begin
        rdEn    = 1'b1;
        rawAddr = bus.ram_rd_data;
        state_d = A_CAP;
      end
      A_CAP: begin
        aData_d = bus.ram_rd_data;
        if (needsRam(bMode_q)) begin
          state_d = B_ISSUE;
        end else begin
          bData_d = directValue(bMode_q, bSel_q, acc_q);
          state_d = EXEC;
        end
      end
      B_ISSUE: begin
        rdEn    = 1'b1;
        rawAddr = issueAddr(bMode_q, bSel_q, bank_q);
        state_d = (bMode_q == 3'd3) ? B_IND : B_CAP;
      end
      B_IND: begin
        rdEn    = 1'b1;
        rawAddr = bus.ram_rd_data;
        state_d = B_CAP;
      end
      B_CAP: begin
        bData_d = bus.ram_rd_data;
        state_d = EXEC;
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      aMode_q <= '0;
      aSel_q  <= '0;
      bMode_q <= '0;
      bSel_q  <= '0;
      acc_q   <= '0;
      bank_q  <= '0;
      aData_q <= '0;
      bData_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      aMode_q <= aMode_d;
      aSel_q  <= aSel_d;
      bMode_q <= bMode_d;
      bSel_q  <= bSel_d;
      acc_q   <= acc_d;
      bank_q  <= bank_d;
      aData_q <= aData_d;
      bData_q <= bData_d;
    end
  end

  // rawAddr is already zero outside ISSUE/IND; the cast drops bits above RAM_AW.
  assign bus.ram_rd_en   = rdEn;
  assign bus.ram_rd_addr = RAM_AW'(rawAddr);
  assign bus.a_data      = aData_q;
  assign bus.b_data      = bData_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_en      = (state_q == EXEC);
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed self-checking bench for alu_operand_fetch: each operation is traced for
// ten cycles after start and the trace is compared against hand-computed values.
module tb_alu_operand_fetch;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_operand_fetch_if #(.RAM_AW(8)) bus ();

  alu_operand_fetch #(.RAM_AW(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [7:0] ram [256];

  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_rd_data <= ram[bus.ram_rd_addr];
  end

  int         checks = 0;
  int         errors = 0;
  int         enCount, firstEnCycle, lastEnCycle, idleAddrBad;
  logic [7:0] firstA, firstB, lastA, lastB, finalA, finalB;
  logic [4:0] firstOp, lastOp;
  logic [15:0] rdMask, busyMask;
  logic [7:0] rdAddrLog [16];
  logic       snap3;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called #1 after a rising edge: start is sampled at the next edge (end of cycle 0).
  // Inputs are then scrambled so that only latched values can produce correct results.
  task automatic applyStimulus(input logic [2:0] am, input logic [7:0] as,
                               input logic [2:0] bm, input logic [7:0] bs,
                               input logic [4:0] op, input logic [7:0] accV,
                               input logic [7:0] pswV, input logic [15:0] startMask,
                               input logic [15:0] rstMask);
    bus.a_mode = am;  bus.a_sel = as;  bus.b_mode = bm;  bus.b_sel = bs;
    bus.op_in  = op;  bus.acc   = accV; bus.psw   = pswV; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a_mode = 3'd0;  bus.a_sel = 8'h55; bus.b_mode = 3'd4; bus.b_sel = 8'hE7;
    bus.op_in  = 5'h1F; bus.acc   = 8'hC3; bus.psw    = 8'hE7;
    enCount = 0; firstEnCycle = 0; lastEnCycle = 0; idleAddrBad = 0;
    rdMask = '0; busyMask = '0; snap3 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.alu_en) begin
        if (enCount == 0) begin
          firstEnCycle = c; firstA = bus.a_data; firstB = bus.b_data; firstOp = bus.alu_op;
        end
        lastEnCycle = c; lastA = bus.a_data; lastB = bus.b_data; lastOp = bus.alu_op;
        enCount++;
      end
      rdMask[c]    = bus.ram_rd_en;
      busyMask[c]  = bus.busy;
      rdAddrLog[c] = bus.ram_rd_addr;
      if (!bus.ram_rd_en && bus.ram_rd_addr != 8'h00) idleAddrBad++;
      if (c == 3) snap3 = |{bus.a_data, bus.b_data, bus.alu_op, bus.alu_en,
                            bus.busy, bus.ram_rd_en, bus.ram_rd_addr};
      if (c == 10) begin finalA = bus.a_data; finalB = bus.b_data; end
      bus.start = startMask[c];
      rst_n     = ~rstMask[c];
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h1A] = 8'h77;
    ram[8'h01] = 8'h40; ram[8'h40] = 8'h9A; ram[8'h30] = 8'h11;
    ram[8'h10] = 8'hFF; ram[8'hFF] = 8'hAB; ram[8'h11] = 8'h20; ram[8'h20] = 8'hCD;
    ram[8'h0D] = 8'h5A;
    ram[8'h00] = 8'h80; ram[8'h80] = 8'h66;

    rst_n = 1'b0;
    bus.start = 1'b1; bus.a_mode = 3'd4; bus.a_sel = 8'hAA; bus.b_mode = 3'd4;
    bus.b_sel = 8'hBB; bus.op_in = 5'h11; bus.acc = 8'h22; bus.psw = 8'h18;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst a_data", bus.a_data, 8'h00);
    checkOutput("rst b_data", bus.b_data, 8'h00);
    checkOutput("rst alu_op", bus.alu_op, 5'h00);
    checkOutput("rst alu_en", bus.alu_en, 1'b0);
    checkOutput("rst busy", bus.busy, 1'b0);
    checkOutput("rst ram_rd_en", bus.ram_rd_en, 1'b0);
    checkOutput("rst ram_rd_addr", bus.ram_rd_addr, 8'h00);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst_n     = 1'b1;

    // ACC + immediate: zero RAM traffic, EXEC in cycle 1
    applyStimulus(3'd0, 8'h00, 3'd4, 8'h05, 5'h00, 8'h3C, 8'h00, 16'h0, 16'h0);
    checkOutput("accimm en cycle", firstEnCycle, 1);
    checkOutput("accimm en count", enCount, 1);
    checkOutput("accimm a_data", firstA, 8'h3C);
    checkOutput("accimm b_data", firstB, 8'h05);
    checkOutput("accimm alu_op", firstOp, 5'h00);
    checkOutput("accimm rd mask", rdMask, 16'h0000);
    checkOutput("accimm busy mask", busyMask, 16'h0002);

    // Rn with bank 3
    applyStimulus(3'd1, 8'h02, 3'd0, 8'h00, 5'h0A, 8'h01, 8'h18, 16'h0, 16'h0);
    checkOutput("rn rd mask", rdMask, 16'h0002);
    checkOutput("rn addr c1", rdAddrLog[1], 8'h1A);
    checkOutput("rn en cycle", firstEnCycle, 3);
    checkOutput("rn a_data", firstA, 8'h77);
    checkOutput("rn b_data", firstB, 8'h01);
    checkOutput("rn alu_op", firstOp, 5'h0A);
    checkOutput("rn busy mask", busyMask, 16'h000E);
    checkOutput("rn hold a_data", finalA, 8'h77);
    checkOutput("rn idle addr", idleAddrBad, 0);

    // Indirect @R1 then direct
    applyStimulus(3'd3, 8'h01, 3'd2, 8'h30, 5'h04, 8'h00, 8'h00, 16'h0, 16'h0);
    checkOutput("inddir rd mask", rdMask, 16'h0016);
    checkOutput("inddir addr c1", rdAddrLog[1], 8'h01);
    checkOutput("inddir addr c2", rdAddrLog[2], 8'h40);
    checkOutput("inddir addr c4", rdAddrLog[4], 8'h30);
    checkOutput("inddir en cycle", firstEnCycle, 6);
    checkOutput("inddir a_data", firstA, 8'h9A);
    checkOutput("inddir b_data", firstB, 8'h11);
    checkOutput("inddir busy mask", busyMask, 16'h007E);

    // Worst case: both operands indirect, bank 2, pointer 0xFF
    applyStimulus(3'd3, 8'h00, 3'd3, 8'h01, 5'h09, 8'h00, 8'h10, 16'h0, 16'h0);
    checkOutput("indind rd mask", rdMask, 16'h0036);
    checkOutput("indind addr c1", rdAddrLog[1], 8'h10);
    checkOutput("indind addr c2", rdAddrLog[2], 8'hFF);
    checkOutput("indind addr c4", rdAddrLog[4], 8'h11);
    checkOutput("indind addr c5", rdAddrLog[5], 8'h20);
    checkOutput("indind en cycle", firstEnCycle, 7);
    checkOutput("indind a_data", firstA, 8'hAB);
    checkOutput("indind b_data", firstB, 8'hCD);
    checkOutput("indind busy mask", busyMask, 16'h00FE);
    checkOutput("indind hold b_data", finalB, 8'hCD);
    checkOutput("indind idle addr", idleAddrBad, 0);

    // Start while busy (cycle 2) ignored; start in cycle 4 runs the scrambled ACC+imm op
    applyStimulus(3'd1, 8'h05, 3'd4, 8'h21, 5'h03, 8'h00, 8'h08, 16'h0014, 16'h0);
    checkOutput("busy en count", enCount, 2);
    checkOutput("busy addr c1", rdAddrLog[1], 8'h0D);
    checkOutput("busy first en", firstEnCycle, 3);
    checkOutput("busy first a", firstA, 8'h5A);
    checkOutput("busy first b", firstB, 8'h21);
    checkOutput("busy first op", firstOp, 5'h03);
    checkOutput("busy second en", lastEnCycle, 5);
    checkOutput("busy second a", lastA, 8'hC3);
    checkOutput("busy second b", lastB, 8'hE7);
    checkOutput("busy second op", lastOp, 5'h1F);
    checkOutput("busy busy mask", busyMask, 16'h002E);

    // Reset during cycle 2 of an indirect fetch
    applyStimulus(3'd3, 8'h00, 3'd0, 8'h00, 5'h0C, 8'h44, 8'h00, 16'h0, 16'h0004);
    checkOutput("midrst en count", enCount, 0);
    checkOutput("midrst outputs c3", snap3, 1'b0);
    checkOutput("midrst busy mask", busyMask, 16'h0006);
    applyStimulus(3'd0, 8'h00, 3'd4, 8'h34, 5'h07, 8'h12, 8'h00, 16'h0, 16'h0);
    checkOutput("postrst en cycle", firstEnCycle, 1);
    checkOutput("postrst a_data", firstA, 8'h12);
    checkOutput("postrst b_data", firstB, 8'h34);
    checkOutput("postrst alu_op", firstOp, 5'h07);

    // Reserved modes read as constant zero with no RAM access
    applyStimulus(3'd6, 8'hFF, 3'd7, 8'hAA, 5'h15, 8'h99, 8'h00, 16'h0, 16'h0);
    checkOutput("inv en cycle", firstEnCycle, 1);
    checkOutput("inv a_data", firstA, 8'h00);
    checkOutput("inv b_data", firstB, 8'h00);
    checkOutput("inv alu_op", firstOp, 5'h15);
    checkOutput("inv rd mask", rdMask, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
